dmem_responder: RTL and testbench

Data-memory responder for the pipelined CPU: the memory side of the core's load/store request interface. Accepts one request per handshake from the MEM stage, holds it for a configurable number of wait states, commits writes or fetches read data, and returns a single-cycle acknowledge. While a request is outstanding, `o_busy` stalls the pipeline, the same way the hazard unit freezes PC and IF/ID.

---
 rtl/dmem_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory side of the CPU's load/store request interface. One request is
// accepted per handshake while idle. It is held for WAIT_CYCLES wait states,
// the store is committed or the load word fetched, and a single-cycle
// acknowledge is returned. o_busy stays high from the accept until the
// acknowledge cycle has ended, so the core can freeze its MEM stage and
// everything upstream of it.
//
// Parameters
//   ADDR_W       word-address bits; the array holds 2**ADDR_W 32-bit words
//   WAIT_CYCLES  wait states between accept and acknowledge (0..15)
//
// Optional feature macro
//   DMEM_BYTE_STROBE_EN  adds i_be. Stores write only the enabled byte lanes.
//                        i_addr[1:0] is not checked for alignment. A store
//                        with no lane enabled is an error. When the macro is
//                        undefined, stores are full-word and any request with
//                        i_addr[1:0] != 0 is an error.
//
// Ports
//   i_clk    in   1   clock, rising edge
//   i_rst    in   1   asynchronous active-high reset
//   i_req    in   1   request valid, sampled only while o_busy = 0
//   i_we     in   1   1 = store, 0 = load
//   i_addr   in  32   byte address
//   i_wdata  in  32   store data
//   i_be     in   4   byte-lane enables, lane 0 = bits 7:0 (macro only)
//   o_busy   out  1   request outstanding; stall the pipeline
//   o_ack    out  1   one-cycle completion pulse
//   o_rdata  out 32   load data, valid with o_ack and held to the next o_ack
//   o_err    out  1   error flag of the acknowledged request, held likewise
//
// Timing (request accepted at edge T)
//   o_busy rises after T. o_ack, o_rdata and o_err are valid in the cycle
//   after edge T+1+WAIT_CYCLES. o_busy falls after edge T+2+WAIT_CYCLES.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  i_be,
`endif
    output logic        o_busy,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    // Illegal wait-state counts are caught when the design is elaborated.
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic        err_q;

    // Request latched at accept; every later decision reads only these
    // registers, so the core may change its request lines while we are busy.
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  be_q;
`endif

    logic [31:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              range_err;
    logic              align_err;
    logic              req_err;
    logic              commit;
    logic              mem_we;
    logic [3:0]        lane_we;
    logic [31:0]       rdata_d;

    // ------------------------------------------------------------------
    // Decode of the latched request
    // ------------------------------------------------------------------
    assign word_idx  = addr_q[ADDR_W+1:2];

    // Any address bit above the array's byte range makes the request
    // out of range; such addresses would otherwise alias into the array.
    assign range_err = |(addr_q >> (ADDR_W + 2));

`ifdef DMEM_BYTE_STROBE_EN
    // Sub-word access is expressed through the lane enables, so the low
    // address bits are ignored. A store that enables no lane is an error.
    assign align_err = we_q && (be_q == 4'b0000);
    assign lane_we   = be_q;
`else
    assign align_err = |addr_q[1:0];
    assign lane_we   = 4'b1111;
`endif

    assign req_err = range_err | align_err;

    // The array is accessed on the edge that moves WAIT into RESP.
    assign commit  = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign mem_we  = commit && we_q && !req_err;

    always_comb begin
        // NOTE: rdata_d gets a value before any condition, so this block
        // can never infer a latch.
        rdata_d = 32'h0;
        if (!req_err && !we_q) begin
            rdata_d = mem_q[word_idx];
        end
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    // NOTE: the array has no reset. Clearing it would turn a RAM into
    // thousands of flops, and its contents are meant to survive i_rst.
    // A store still in flight is dropped because the async reset forces
    // state_q back to IDLE, which removes mem_we before the next edge.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && lane_we[b]) begin
                mem_q[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // WAIT always lasts at least one cycle. The counter is loaded with
    // WAIT_CYCLES and RESP is entered on the edge where it is already
    // zero. The acknowledge therefore lands WAIT_CYCLES+1 edges after
    // the accept, and with WAIT_CYCLES = 0 the block accepts every
    // third edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: state is updated with non-blocking assignments only, so
            // every register samples the values from before this edge.
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
`ifdef DMEM_BYTE_STROBE_EN
            be_q    <= 4'b0000;
`endif
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_req) begin
                        we_q    <= i_we;
                        addr_q  <= i_addr;
                        wdata_q <= i_wdata;
`ifdef DMEM_BYTE_STROBE_EN
                        be_q    <= i_be;
`endif
                        cnt_q   <= WAIT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        // rdata_q and err_q hold until the next acknowledge.
                        ack_q   <= 1'b1;
                        rdata_q <= rdata_d;
                        err_q   <= req_err;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                ST_RESP: begin
                    // No accept from RESP: the following IDLE cycle is the
                    // first one in which i_req is sampled again.
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy  = busy_q;
    assign o_ack   = ack_q;
    assign o_rdata = rdata_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two instances share the request lines: u_dut2 (WAIT_CYCLES = 2) and u_dut0
// (WAIT_CYCLES = 0); each has its own i_req. Expected values come from
// constant vector tables, hand-written sequences and a sparse-memory
// reference model of the storage rules.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req2, req0;
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;

    logic        busy2, ack2, err2;
    logic [31:0] rdata2;
    logic        busy0, ack0, err0;
    logic [31:0] rdata0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) u_dut2 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req2),
        .i_we    (we),
        .i_addr  (addr),
        .i_wdata (wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .i_be    (be),
`endif
        .o_busy  (busy2),
        .o_ack   (ack2),
        .o_rdata (rdata2),
        .o_err   (err2)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req0),
        .i_we    (we),
        .i_addr  (addr),
        .i_wdata (wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .i_be    (be),
`endif
        .o_busy  (busy0),
        .o_ack   (ack0),
        .o_rdata (rdata0),
        .o_err   (err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // One complete request on the selected instance (sel=1 -> u_dut0).
    // Accepted on the first edge, then the acknowledge must come exactly
    // WAIT_CYCLES+1 edges later. With junk=1, random traffic is driven on
    // the request lines while busy; it must be ignored.
    // ------------------------------------------------------------------
    task automatic do_req(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input bit exp_err, input bit chk_rd,
                          input logic [31:0] exp_rd, input bit junk, input string tag);
        int lat;
        bit got;
        int wc;
        wc = sel ? 0 : 2;
        @(negedge clk);
        we = w; addr = a; wdata = d; be = b;
        if (sel) req0 = 1'b1; else req2 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; req2 = 1'b0;
        check({tag, " busy after accept"}, sel ? busy0 : busy2, 32'd1);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            if (junk) begin
                @(negedge clk);
                we    = 1'($urandom_range(0, 1));
                addr  = $urandom;
                wdata = $urandom;
                be    = 4'($urandom_range(0, 15));
                if (sel) req0 = 1'($urandom_range(0, 1)); else req2 = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if (sel ? ack0 : ack2) begin
                got = 1'b1;
                lat = k;
            end
        end
        req0 = 1'b0; req2 = 1'b0;
        check({tag, " ack latency"}, lat, wc + 1);
        if (got) begin
            check({tag, " err"}, sel ? err0 : err2, {31'd0, exp_err});
            if (chk_rd) check({tag, " rdata"}, sel ? rdata0 : rdata2, exp_rd);
            check({tag, " busy in ack cycle"}, sel ? busy0 : busy2, 32'd1);
            @(posedge clk); #1;
            check({tag, " busy after ack"}, sel ? busy0 : busy2, 32'd0);
            check({tag, " ack single cycle"}, sel ? ack0 : ack2, 32'd0);
            if (chk_rd) check({tag, " rdata held"}, sel ? rdata0 : rdata2, exp_rd);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model for u_dut2: a sparse word store plus the error rules.
    // ------------------------------------------------------------------
    logic [31:0] mdl_mem [int unsigned];

    function automatic bit mdl_err(input bit w, input logic [31:0] a, input logic [3:0] b);
        bit e;
        e = (a >> (ADDR_W + 2)) != 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
        if (w && b == 4'b0000) e = 1'b1;
`else
        if (a[1:0] != 2'b00) e = 1'b1;
        if (w && b == 4'b0000) e = e;
`endif
        return e;
    endfunction

    task automatic model_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, input bit junk, input string tag);
        bit          e;
        bit          chk;
        logic [31:0] exp;
        logic [31:0] cur;
        int unsigned wi;
        e   = mdl_err(w, a, b);
        chk = 1'b0;
        exp = 32'h0;
        wi  = int'(a[ADDR_W+1:2]);
        if (e) begin
            chk = 1'b1;
        end else if (w) begin
            cur = mdl_mem.exists(wi) ? mdl_mem[wi] : 32'h0;
            for (int l = 0; l < 4; l++) if (b[l]) cur[8*l +: 8] = d[8*l +: 8];
            mdl_mem[wi] = cur;
        end else if (mdl_mem.exists(wi)) begin
            chk = 1'b1;
            exp = mdl_mem[wi];
        end
        do_req(1'b0, w, a, d, b, e, chk, exp, junk, tag);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] b, input bit e, input bit c,
                                input logic [31:0] r, input string n);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.be = b;
        v.exp_err = e; v.chk_rd = c; v.exp_rd = r; v.name = n;
        tbl.push_back(v);
    endfunction

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        bit          rw;
        logic [3:0]  rb;
        int          kind;

        rst = 1'b1; req2 = 1'b0; req0 = 1'b0;
        we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'hF;

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        check("reset busy2",  busy2,  32'd0);
        check("reset ack2",   ack2,   32'd0);
        check("reset rdata2", rdata2, 32'd0);
        check("reset err2",   err2,   32'd0);
        check("reset busy0",  busy0,  32'd0);
        check("reset ack0",   ack0,   32'd0);
        check("reset rdata0", rdata0, 32'd0);
        check("reset err0",   err0,   32'd0);
        #1 rst = 1'b0;

`ifdef DMEM_BYTE_STROBE_EN
        add(1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        "st 0x10");
        add(0, 32'h10,       32'h0,        4'hF, 0, 1, 32'hDEADBEEF, "ld 0x10");
        add(1, 32'h8,        32'h0,        4'hF, 0, 0, 32'h0,        "clr 0x8");
        add(1, 32'h8,        32'hAABBCCDD, 4'h5, 0, 0, 32'h0,        "st be0101 0x8");
        add(0, 32'h8,        32'h0,        4'hF, 0, 1, 32'h00BB00DD, "ld 0x8 lanes");
        add(1, 32'h4,        32'h00000777, 4'hF, 0, 0, 32'h0,        "st 0x4");
        add(1, 32'h4,        32'h00000055, 4'h0, 1, 1, 32'h0,        "st be0 err");
        add(0, 32'h4,        32'h0,        4'hF, 0, 1, 32'h00000777, "ld 0x4 unchanged");
        add(0, 32'h1000,     32'h0,        4'hF, 1, 1, 32'h0,        "ld out of range");
        add(0, 32'h6,        32'h0,        4'hF, 0, 1, 32'h00000777, "ld 0x6 unaligned ok");
        add(1, 32'hFFC,      32'h12345678, 4'hF, 0, 0, 32'h0,        "st top word");
        add(0, 32'hFFC,      32'h0,        4'hF, 0, 1, 32'h12345678, "ld top word");
`else
        add(1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        "st 0x10");
        add(0, 32'h10,       32'h0,        4'hF, 0, 1, 32'hDEADBEEF, "ld 0x10");
        add(1, 32'h4,        32'h00000777, 4'hF, 0, 0, 32'h0,        "st 0x4");
        add(0, 32'h1000,     32'h0,        4'hF, 1, 1, 32'h0,        "ld out of range");
        add(1, 32'h1004,     32'h00000055, 4'hF, 1, 1, 32'h0,        "st out of range");
        add(0, 32'h4,        32'h0,        4'hF, 0, 1, 32'h00000777, "ld 0x4 after oor st");
        add(1, 32'h6,        32'h00000055, 4'hF, 1, 1, 32'h0,        "st 0x6 misaligned");
        add(0, 32'h4,        32'h0,        4'hF, 0, 1, 32'h00000777, "ld 0x4 after mis st");
        add(0, 32'h13,       32'h0,        4'hF, 1, 1, 32'h0,        "ld 0x13 misaligned");
        add(1, 32'hFFC,      32'h12345678, 4'hF, 0, 0, 32'h0,        "st top word");
        add(0, 32'hFFC,      32'h0,        4'hF, 0, 1, 32'h12345678, "ld top word");
        add(0, 32'h80000010, 32'h0,        4'hF, 1, 1, 32'h0,        "ld high bit oor");
        add(0, 32'h10,       32'h0,        4'hF, 0, 1, 32'hDEADBEEF, "ld 0x10 again");
`endif
        foreach (tbl[i]) begin
            do_req(1'b0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be,
                   tbl[i].exp_err, tbl[i].chk_rd, tbl[i].exp_rd, 1'b0, tbl[i].name);
        end

        // Reset in the middle of WAIT drops the store and clears outputs at once.
        do_req(1'b0, 1'b1, 32'h20, 32'h11111111, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, "pre 0x20");
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b1, 32'h11111111, 1'b0, "ld 0x20");
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'h22222222; be = 4'hF; req2 = 1'b1;
        @(posedge clk); #1;
        req2 = 1'b0;
        check("rst seq busy before reset", busy2, 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async rst busy",  busy2,  32'd0);
        check("async rst ack",   ack2,   32'd0);
        check("async rst rdata", rdata2, 32'd0);
        check("async rst err",   err2,   32'd0);
        @(posedge clk); #1;
        check("held rst ack", ack2, 32'd0);
        #1 rst = 1'b0;
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b1, 32'h11111111, 1'b0, "ld 0x20 after rst");

        // WAIT_CYCLES=0 with i_req held high: accept every third edge; data
        // offered on the busy edges must be ignored.
        @(negedge clk);
        we = 1'b1; addr = 32'h0; wdata = 32'h100; be = 4'hF; req0 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            check($sformatf("b2b busy edge %0d", k), busy0, (k % 3 != 0) ? 32'd1 : 32'd0);
            check($sformatf("b2b ack edge %0d", k),  ack0,  (k % 3 == 2) ? 32'd1 : 32'd0);
            @(negedge clk);
            wdata = 32'h100 + 32'(k);
        end
        req0 = 1'b0;
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h106, 1'b0, "w0 ld last accepted");
        do_req(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, 1'b0, "w0 ld out of range");

        // Randomised traffic on u_dut2 against the reference model.
        for (int i = 0; i < 32; i++) begin
            model_req(1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, 1'b0, "rnd preload");
        end
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            rw   = 1'($urandom_range(0, 1));
            if (kind == 0)      ra = ($urandom & 32'hFFFF_FFFC) | 32'h1000;
            else if (kind == 1) ra = 32'h100 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
            else                ra = 32'h100 + 32'(4 * $urandom_range(0, 31));
`ifdef DMEM_BYTE_STROBE_EN
            rb = 4'($urandom_range(0, 15));
`else
            rb = 4'hF;
`endif
            model_req(rw, ra, $urandom, rb, 1'($urandom_range(0, 1)), $sformatf("rnd %0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
